// File: rtl/ndsource.sv
// ndsource: non-deterministic token producer driving the producer end of a
// valid/ready channel. nd_start/nd_data are free choice inputs; the optional
// token budget (MAX_TOKENS) bounds the total number of transfers.
//
// Handshake: a transfer happens in any cycle with outs_valid && outs_ready.
// Once outs_valid is high, outs_valid and outs hold until that transfer.
// outs_ready while outs_valid is low has no effect.
module ndsource #(
  parameter int DATA_TYPE   = 32,
  parameter int MAX_TOKENS  = 0,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   nd_start,
  input  logic [DATA_TYPE-1:0]   nd_data,
  output logic [DATA_TYPE-1:0]   outs,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [COUNT_WIDTH-1:0] token_count,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam bit                     LIMITED = (MAX_TOKENS != 0);
  localparam logic [COUNT_WIDTH-1:0] BUDGET  = COUNT_WIDTH'(MAX_TOKENS);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [DATA_TYPE-1:0]   outs_q, outs_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] cnt_inc;

  // Saturating increment: the counter never wraps in unlimited mode.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNT_WIDTH'(1);

  // State, payload and counter registers; reset discards any pending token.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      outs_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: choice points only in IDLE and on a completed transfer.
  always_comb begin
    state_d = state_q;
    outs_d  = outs_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (LIMITED && cnt_q == BUDGET) begin
          state_d = DONE;
        end else if (nd_start) begin
          outs_d  = nd_data;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // Without outs_ready the offer persists untouched.
        if (outs_ready) begin
          cnt_d = cnt_inc;
          if (LIMITED && cnt_inc == BUDGET) begin
            state_d = DONE;
          end else if (nd_start) begin
            outs_d  = nd_data;
            state_d = OFFER;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign outs        = outs_q;
  assign outs_valid  = (state_q == OFFER);
  assign done        = (state_q == DONE);
  assign token_count = cnt_q;

endmodule

// File: tb/tb_ndsource.sv
// tb_ndsource: three ndsource instances (unlimited, budget of 3, 2-bit
// saturating counter) share one stimulus stream and are checked against a
// token-level reference model plus an expected-token queue.
module tb_ndsource;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        nd_start;
  logic [31:0] nd_data;
  logic        outs_ready;

  logic [31:0] outs0, outs1, outs2;
  logic        v0, v1, v2;
  logic [7:0]  c0, c1;
  logic [1:0]  c2;
  logic        d0, d1, d2;

  ndsource #(.DATA_TYPE(32), .MAX_TOKENS(0), .COUNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .nd_start(nd_start), .nd_data(nd_data),
    .outs(outs0), .outs_valid(v0), .outs_ready(outs_ready),
    .token_count(c0), .done(d0));

  ndsource #(.DATA_TYPE(32), .MAX_TOKENS(3), .COUNT_WIDTH(8)) u_bud (
    .clk(clk), .rst(rst), .nd_start(nd_start), .nd_data(nd_data),
    .outs(outs1), .outs_valid(v1), .outs_ready(outs_ready),
    .token_count(c1), .done(d1));

  ndsource #(.DATA_TYPE(32), .MAX_TOKENS(0), .COUNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .nd_start(nd_start), .nd_data(nd_data),
    .outs(outs2), .outs_valid(v2), .outs_ready(outs_ready),
    .token_count(c2), .done(d2));

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];            // tokens expected from u_dut, in order
  int          m_max[3] = '{0, 3, 0};
  int          m_sat[3] = '{255, 255, 3};
  bit          m_pend[3];           // a token is being offered
  bit          m_done[3];
  int          m_cnt[3];
  logic [31:0] m_data[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 1'b0;
      m_done[i] = 1'b0;
      m_cnt[i]  = 0;
      m_data[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic model_load(input int i);
    m_pend[i] = 1'b1;
    m_data[i] = nd_data;
    if (i == 0) exp_q.push_back(nd_data);
  endtask

  // One clock edge of behaviour, in terms of "offer pending" and "budget spent".
  task automatic model_step(input int i);
    bool_dummy_free: begin end
    if (m_done[i]) return;
    if (m_pend[i]) begin
      if (outs_ready) begin
        if (m_cnt[i] < m_sat[i]) m_cnt[i]++;
        m_pend[i] = 1'b0;
        if (m_max[i] != 0 && m_cnt[i] == m_max[i]) m_done[i] = 1'b1;
        else if (nd_start) model_load(i);
      end
    end else if (m_max[i] != 0 && m_cnt[i] == m_max[i]) begin
      m_done[i] = 1'b1;
    end else if (nd_start) begin
      model_load(i);
    end
  endtask

  task automatic compare_all();
    logic [31:0] o, c;
    logic        v, d;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin o = outs0; v = v0; c = 32'(c0); d = d0; end
        1:       begin o = outs1; v = v1; c = 32'(c1); d = d1; end
        default: begin o = outs2; v = v2; c = 32'(c2); d = d2; end
      endcase
      check($sformatf("i%0d_valid", i), 32'(v), 32'(m_pend[i]));
      check($sformatf("i%0d_done", i),  32'(d), 32'(m_done[i]));
      check($sformatf("i%0d_count", i), c, 32'(m_cnt[i]));
      check($sformatf("i%0d_outs", i),  o, m_data[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set before calling; transfer order is checked before the edge.
  task automatic cycle();
    if (rst && m_pend[0] && outs_ready) begin
      if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else check("sb_token", outs0, exp_q.pop_front());
    end
    @(posedge clk);
    if (!rst) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    cycle();
    rst = 1'b1;
  endtask

  int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; nd_start = 1'b1; nd_data = 32'h0; outs_ready = 1'b0;
    model_reset();

    // Reset holds everything idle even with nd_start high.
    for (int k = 0; k < 3; k++) cycle();
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_count", 32'(c0), 32'd0);
    check("rst_done",  32'(d1), 32'd0);

    // Release with a choice pending: offer one cycle later.
    rst = 1'b1; nd_data = 32'hA5;
    cycle();
    check("rel_valid", 32'(v0), 32'd1);
    check("rel_outs",  outs0, 32'hA5);

    // Backpressure: payload and valid persist while inputs wiggle.
    do_reset();
    nd_start = 1'b1; nd_data = 32'h11; outs_ready = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      nd_start = k[0];
      nd_data  = $urandom;
      cycle();
      check("bp_outs",  outs0, 32'h11);
      check("bp_valid", 32'(v0), 32'd1);
    end
    outs_ready = 1'b1; nd_start = 1'b0;
    cycle();
    check("bp_count", 32'(c0), 32'd1);

    // Back-to-back tokens with valid continuously high.
    do_reset();
    outs_ready = 1'b1; nd_start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      nd_data = 32'(k);
      cycle();
      check("b2b_outs",  outs0, 32'(k));
      check("b2b_valid", 32'(v0), 32'd1);
    end
    nd_start = 1'b0;
    cycle();
    check("b2b_count", 32'(c0), 32'd4);

    // Budget: u_bud stops after three transfers and ignores further starts.
    for (int k = 0; k < 4; k++) begin
      nd_start = ~nd_start; nd_data = $urandom;
      cycle();
      check("bud_done",  32'(d1), 32'd1);
      check("bud_valid", 32'(v1), 32'd0);
      check("bud_count", 32'(c1), 32'd3);
    end

    // Saturation of the 2-bit counter.
    do_reset();
    outs_ready = 1'b1; nd_start = 1'b1; nd_data = 32'h5A;
    cycle();
    for (int k = 0; k < 6; k++) begin
      nd_data = $urandom;
      cycle();
      check("sat_count", 32'(c2), 32'(sat_exp[k]));
    end

    // Asynchronous reset in the middle of a pending offer.
    outs_ready = 1'b0; nd_start = 1'b1;
    cycle();
    check("pre_arst_valid", 32'(v0), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(v0), 32'd0);
    check("arst_count", 32'(c0), 32'd0);
    check("arst_done",  32'(d1), 32'd0);
    model_reset();
    @(negedge clk);
    cycle();
    rst = 1'b1;

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 49) != 0);
      nd_start   = 1'($urandom_range(0, 1));
      outs_ready = ($urandom_range(0, 3) != 0);
      nd_data    = $urandom;
      if (!rst) model_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ndsource.md
Name: ndsource

Overview:
Non-deterministic token producer for formal verification and randomized simulation of handshake circuits. It drives the producer end of a valid/ready channel and respects the channel's persistence obligations: once valid is raised, valid and data hold until the consumer accepts. Choice points come from explicit free inputs, so formal tools treat them as primary inputs. An optional token budget bounds the total number of emitted tokens for bounded proofs.

Parameters:
DATA_TYPE, 32, width in bits of the output data channel (must be >= 1)
MAX_TOKENS, 0, total tokens to emit before stopping; 0 = unlimited
COUNT_WIDTH, 8, width of the token counter; must satisfy MAX_TOKENS <= 2^COUNT_WIDTH-1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
nd_start  input  1  free non-deterministic choice: offer a new token when allowed
nd_data  input  DATA_TYPE  free non-deterministic payload, sampled only at load points
outs  output  DATA_TYPE  output data, registered
outs_valid  output  1  output valid
outs_ready  input  1  consumer ready
token_count  output  COUNT_WIDTH  number of completed transfers, registered
done  output  1  high when the budget is exhausted

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, outs=0, token_count=0, outs_valid=0, done=0. Releasing reset needs no extra idle cycle.
- States: IDLE, OFFER, DONE. outs_valid=1 iff state=OFFER. done=1 iff state=DONE. Both are decoded from registered state, with no combinational path from any input.
- A transfer occurs in a cycle where outs_valid=1 and outs_ready=1.
- IDLE:
  - If MAX_TOKENS!=0 and token_count==MAX_TOKENS, go to DONE. This covers MAX_TOKENS reached only via reset corner cases and is checked first.
  - Otherwise, if nd_start=1, load outs<=nd_data and go to OFFER; valid appears the next cycle (1-cycle latency from choice to offer).
  - Otherwise stay in IDLE.
- OFFER without a transfer: stay in OFFER; outs and outs_valid are unchanged. nd_start and nd_data are ignored. This is the persistence obligation: no retraction and no data change.
- OFFER with a transfer:
  - token_count increments. In unlimited mode it saturates at 2^COUNT_WIDTH-1 and never wraps.
  - If MAX_TOKENS!=0 and the new count equals MAX_TOKENS, go to DONE.
  - Else, if nd_start=1 in the same cycle, load outs<=nd_data and remain in OFFER. This gives back-to-back tokens with valid continuously high and a throughput of 1 token/cycle.
  - Else go to IDLE; outs keeps its last value (don't-care while valid=0).
- DONE: terminal state. outs_valid=0, done=1, inputs ignored, token_count frozen. Only reset leaves DONE.
- outs_ready may be high while outs_valid=0; this has no effect.
- Reset mid-offer: a pending untransferred token is discarded and the counter clears. Consumers must be reset together with the source.
- Formal note: leaving nd_start and nd_data unconstrained must yield every legal producer behaviour. Assertions for verification:
  - outs_valid && !outs_ready |=> outs_valid && $stable(outs)
  - token_count <= MAX_TOKENS when MAX_TOKENS!=0

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles with nd_start=1 -> outs_valid=0, token_count=0, done=0. Release rst with nd_start=1 and nd_data=0xA5 -> outs_valid=1 and outs=0xA5 one cycle later.
- Backpressure: in OFFER with outs=0x11, hold outs_ready=0 for 5 cycles while nd_data toggles and nd_start toggles -> outs stays 0x11 with valid high every cycle. Raise outs_ready -> token_count=1.
- Back-to-back: outs_ready=1, nd_start=1, nd_data=1,2,3,4 on consecutive cycles -> outs=1,2,3,4 on consecutive cycles, valid never drops, token_count=4.
- Budget: MAX_TOKENS=3, always ready, nd_start=1 -> exactly 3 transfers, then done=1 and outs_valid=0 permanently; further nd_start pulses give no valid.
- Saturation: MAX_TOKENS=0, COUNT_WIDTH=2, 6 transfers -> token_count reads 1,2,3,3,3,3.
- Asynchronous reset mid-offer: assert rst=0 between clock edges while outs_valid=1 -> outs_valid and token_count drop to 0 immediately, without waiting for a clock edge.
